// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Holds the ALU opcode constants, the arbiter FSM state type and the
// default operand width used by alu_arbiter and ALU.
package alu_arb_pkg;

  localparam int unsigned ALU_ARB_DATA_WIDTH = 32;
  localparam int unsigned OP_WIDTH           = 4;
  localparam int unsigned CNT_WIDTH          = 16;

  typedef logic [OP_WIDTH-1:0] alu_op_t;

  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ALU.sv
// Combinational ALU shared by the arbiter.
// Ports:
//   a_i, b_i    operands
//   op_i        opcode (ADD/SUB/AND/OR; unknown codes add)
//   result_c_o  result, wraps modulo 2^WIDTH
//   zero_c_o    high when result_c_o is zero
module ALU
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_ARB_DATA_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_t          op_i,
  output logic [WIDTH-1:0] result_c_o,
  output logic             zero_c_o
);

  always_comb begin
    result_c_o = a_i + b_i;
    case (op_i)
      ALU_ADD: result_c_o = a_i + b_i;
      ALU_SUB: result_c_o = a_i - b_i;
      ALU_AND: result_c_o = a_i & b_i;
      ALU_OR:  result_c_o = a_i | b_i;
      default: result_c_o = a_i + b_i;
    endcase
    zero_c_o = (result_c_o == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with a round-robin grant.
// FSM: IDLE (grant + latch operands) -> EXEC (compute, register result)
//      -> RESP (hold response until rsp_ready).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rqN_valid/rqN_ready      requester N handshake (ready pulses on grant)
//   rqN_a, rqN_b, rqN_op     requester N operands and opcode
//   rsp_valid/rsp_ready      response handshake
//   rsp_id, rsp_result, rsp_zero  response payload
// Optional (macro ALU_ARB_STATS_EN): grant_cnt0, grant_cnt1 saturating
// 16-bit per-requester grant counters.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_ARB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rq0_valid,
  output logic                  rq0_ready,
  input  logic [DATA_WIDTH-1:0] rq0_a,
  input  logic [DATA_WIDTH-1:0] rq0_b,
  input  logic [OP_WIDTH-1:0]   rq0_op,
  input  logic                  rq1_valid,
  output logic                  rq1_ready,
  input  logic [DATA_WIDTH-1:0] rq1_a,
  input  logic [DATA_WIDTH-1:0] rq1_b,
  input  logic [OP_WIDTH-1:0]   rq1_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  grant_cnt0,
  output logic [CNT_WIDTH-1:0]  grant_cnt1
`endif
);

  arb_state_e            state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  gnt0, gnt1;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  alu_op_t               op_q;
  logic                  id_q;
  logic                  rsp_id_q, rsp_zero_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and pointer update
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: if (rq0_valid || rq1_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Pointer always moves to the requester that was not granted
    if (gnt0)      ptr_d = 1'b1;
    else if (gnt1) ptr_d = 1'b0;
  end

  // Grant and handshake outputs; reset masks them in the same cycle
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rsp_valid = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (rq0_valid && rq1_valid) begin
            gnt0 = ~ptr_q;
            gnt1 = ptr_q;
          end else begin
            gnt0 = rq0_valid;
            gnt1 = rq1_valid;
          end
        end
        ST_RESP: rsp_valid = 1'b1;
        default: ;
      endcase
    end
  end

  assign rq0_ready = gnt0;
  assign rq1_ready = gnt1;

  // Operand latch on grant, result capture in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= ALU_AND;
      id_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (gnt0 || gnt1) begin
        a_q  <= gnt1 ? rq1_a  : rq0_a;
        b_q  <= gnt1 ? rq1_b  : rq0_b;
        op_q <= gnt1 ? rq1_op : rq0_op;
        id_q <= gnt1;
      end
      if (state_q == ST_EXEC) begin
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
        rsp_id_q     <= id_q;
      end
    end
  end

  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

  ALU #(
    .WIDTH (DATA_WIDTH)
  ) u_alu (
    .a_i        (a_q),
    .b_i        (b_q),
    .op_i       (op_q),
    .result_c_o (alu_result),
    .zero_c_o   (alu_zero)
  );

`ifdef ALU_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q;

  // Saturating per-requester grant counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_WIDTH'(1);
      if (gnt1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_WIDTH'(1);
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: rq0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: rq0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port: rq0_a, rq0_b  input  DATA_WIDTH  requester 0 operands.
REQ-007 Port: rq0_op  input  4  requester 0 ALU opcode.
REQ-008 Port: rq1_valid, rq1_ready, rq1_a, rq1_b, rq1_op  same directions/widths as REQ-004..007, requester 1.
REQ-009 Port: rsp_valid  output  1  response available.
REQ-010 Port: rsp_ready  input  1  response consumer accepts.
REQ-011 Port: rsp_id  output  1  requester index owning the response.
REQ-012 Port: rsp_result  output  DATA_WIDTH  ALU result.
REQ-013 Port: rsp_zero  output  1  result-equals-zero flag.

Function
REQ-014 Block SHALL share one ALU between two requesters via FSM states IDLE, EXEC, RESP.
REQ-015 IDLE: if any rqN_valid, SHALL grant one requester, assert its rqN_ready for that cycle only, latch its a/b/op/id, go to EXEC; else stay IDLE.
REQ-016 rqN_ready SHALL be asserted only in IDLE, and only to the granted requester; never both.
REQ-017 Both valid in IDLE: grant SHALL go to the requester indicated by a 1-bit round-robin pointer; pointer SHALL flip to the non-granted requester on each grant.
REQ-018 Single valid requester SHALL be granted regardless of pointer; pointer then SHALL point to the other requester.
REQ-019 EXEC: ALU SHALL be driven from latched operands only; result and zero SHALL be registered; go to RESP.
REQ-020 RESP: rsp_valid=1 with rsp_id/rsp_result/rsp_zero stable until rsp_valid&&rsp_ready; on that cycle go to IDLE.
REQ-021 Latency: accept at edge N -> rsp_valid high in cycle N+2; peak throughput one operation per 3 cycles.
REQ-022 Opcodes: 0010 add, 0110 sub, 0000 AND, 0001 OR; any other code SHALL produce add; arithmetic SHALL wrap modulo 2^DATA_WIDTH.
REQ-023 rsp_zero SHALL be 1 iff rsp_result == 0.
REQ-024 Requester operand changes after acceptance SHALL not affect the in-flight response.
REQ-025 rsp_ready held low SHALL stall the FSM in RESP; no new grant.
REQ-026 rsp_ready asserted while rsp_valid low SHALL have no effect.

Reset
REQ-027 rst SHALL force: state IDLE, pointer=0 (requester 0 preferred), rq0_ready=rq1_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, statistics counters 0.
REQ-028 rst mid-operation (EXEC or RESP) SHALL discard the transaction; no response SHALL be issued for it.
REQ-029 rst SHALL dominate all inputs in the same cycle.

Configuration
REQ-030 Macro ALU_ARB_STATS_EN defined: SHALL add outputs grant_cnt0, grant_cnt1 (16 bits each), incremented per grant to that requester, saturating at 0xFFFF.
REQ-031 Macro ALU_ARB_STATS_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-032 Shared package alu_arb_pkg SHALL hold opcode constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR), FSM state typedef, default DATA_WIDTH.
REQ-033 Block SHALL instantiate exactly one sub-module: the team's existing combinational ALU (module ALU); no other arithmetic logic.

Verification
REQ-034 Reset then rq0 only, a=5,b=3,op=0010 -> rq0_ready pulse, 2 cycles later rsp_valid, id=0, result=8, zero=0.
REQ-035 Both valid after reset, rq0 sub 7-7, rq1 OR 0xF0|0x0F -> first rsp id=0 result=0 zero=1; second rsp id=1 result=0xFF.
REQ-036 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; no requester granted twice in a row.
REQ-037 rsp_ready=0 for 5 cycles in RESP -> rsp fields stable, both rqN_ready stay 0; release -> IDLE next cycle.
REQ-038 add 0xFFFFFFFF+1 and op=1111 with a=2,b=2 -> result 0 zero=1; result 4.
REQ-039 rst asserted in EXEC -> rsp_valid never rises for that op; next request gets pointer-0 priority.
